// File: rtl/matmul2x2_pipe.sv
// Two-stage 2x2 matrix multiply stage: registered products, then registered sums.
// Valid/ready on both sides; a stalled output freezes the whole pipeline.
module matmul2x2_pipe #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   A1,
  input  logic [DW-1:0]   A2,
  input  logic [DW-1:0]   A3,
  input  logic [DW-1:0]   A4,
  input  logic [DW-1:0]   B1,
  input  logic [DW-1:0]   B2,
  input  logic [DW-1:0]   B3,
  input  logic [DW-1:0]   B4,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [2*DW:0]   C1,
  output logic [2*DW:0]   C2,
  output logic [2*DW:0]   C3,
  output logic [2*DW:0]   C4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   res_count
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = 2 * DW + 1;

  logic          stall;
  logic          s1_valid_q;
  logic [PW-1:0] prod_q [8];
  logic [PW-1:0] prod_d [8];
  logic [SW-1:0] sum_d  [4];
  logic [SW-1:0] c_q    [4];
  logic          out_valid_q;
  logic [CW-1:0] res_count_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Product order pairs up so that sum k adds prod[2k] and prod[2k+1].
  always_comb begin
    prod_d[0] = PW'(A1) * PW'(B1);
    prod_d[1] = PW'(A2) * PW'(B3);
    prod_d[2] = PW'(A1) * PW'(B2);
    prod_d[3] = PW'(A2) * PW'(B4);
    prod_d[4] = PW'(A3) * PW'(B1);
    prod_d[5] = PW'(A4) * PW'(B3);
    prod_d[6] = PW'(A3) * PW'(B2);
    prod_d[7] = PW'(A4) * PW'(B4);
    for (int k = 0; k < 4; k++) begin
      sum_d[k] = SW'(prod_q[2*k]) + SW'(prod_q[2*k+1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      for (int i = 0; i < 8; i++) prod_q[i] <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 8; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) c_q[k] <= '0;
    end else if (!stall) begin
      out_valid_q <= s1_valid_q;
      for (int k = 0; k < 4; k++) c_q[k] <= sum_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      res_count_q <= res_count_q + CW'(1);
    end
  end

  assign C1        = c_q[0];
  assign C2        = c_q[1];
  assign C3        = c_q[2];
  assign C4        = c_q[3];
  assign out_valid = out_valid_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_matmul2x2_pipe.sv
// Directed bench for matmul2x2_pipe: basic, max values, streaming, backpressure,
// asynchronous reset mid-flight and counter wrap (CW=4).
module tb_matmul2x2_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] A1, A2, A3, A4, B1, B2, B3, B4;
  logic          in_valid;
  logic          in_ready;
  logic [2*DW:0] C1, C2, C3, C4;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] res_count;

  int checks = 0;
  int errors = 0;

  // Hand-computed results for A=[1,2,3,4] with B=[17..20],[21..24],[25..28],[29..32].
  int exp_c [4][4] = '{'{55, 58, 127, 134},
                       '{67, 70, 155, 162},
                       '{79, 82, 183, 190},
                       '{91, 94, 211, 218}};

  matmul2x2_pipe #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .A1        (A1),
    .A2        (A2),
    .A3        (A3),
    .A4        (A4),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3),
    .B4        (B4),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .C1        (C1),
    .C2        (C2),
    .C3        (C3),
    .C4        (C4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_count (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input int c1, input int c2, input int c3, input int c4);
    chk({tag, "_c1"}, 64'(C1), 64'(c1));
    chk({tag, "_c2"}, 64'(C2), 64'(c2));
    chk({tag, "_c3"}, 64'(C3), 64'(c3));
    chk({tag, "_c4"}, 64'(C4), 64'(c4));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int b0);
    A1 = 8'd1; A2 = 8'd2; A3 = 8'd3; A4 = 8'd4;
    B1 = DW'(b0); B2 = DW'(b0 + 1); B3 = DW'(b0 + 2); B4 = DW'(b0 + 3);
    in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A1 = '0; A2 = '0; A3 = '0; A4 = '0;
    B1 = '0; B2 = '0; B3 = '0; B4 = '0;

    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(res_count), 64'd0);
    chk_c("rst", 0, 0, 0, 0);
    #10 rst = 1'b1;

    // Basic: one vector, two-cycle latency.
    drive_vec(17);
    step();
    in_valid = 1'b0;
    chk("basic_lat1", 64'(out_valid), 64'd0);
    step();
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk_c("basic", 55, 58, 127, 134);
    chk("basic_cnt_pre", 64'(res_count), 64'd0);
    step();
    chk("basic_valid_off", 64'(out_valid), 64'd0);
    chk("basic_cnt", 64'(res_count), 64'd1);

    // Max values.
    A1 = 8'hff; A2 = 8'hff; A3 = 8'hff; A4 = 8'hff;
    B1 = 8'hff; B2 = 8'hff; B3 = 8'hff; B4 = 8'hff;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("max_valid", 64'(out_valid), 64'd1);
    chk_c("max", 130050, 130050, 130050, 130050);
    step();
    chk("max_cnt", 64'(res_count), 64'd2);

    // Streaming: four back-to-back vectors.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_vec(17 + 4 * i);
      else in_valid = 1'b0;
      step();
      if (i >= 1) begin
        chk($sformatf("stream%0d_valid", i - 1), 64'(out_valid), 64'd1);
        chk_c($sformatf("stream%0d", i - 1),
              exp_c[i-1][0], exp_c[i-1][1], exp_c[i-1][2], exp_c[i-1][3]);
      end
    end
    step();
    chk("stream_valid_off", 64'(out_valid), 64'd0);
    chk("stream_cnt", 64'(res_count), 64'd6);

    // Backpressure: fill pipeline, stall 5 cycles, release.
    out_ready = 1'b0;
    drive_vec(17);
    step();
    drive_vec(21);
    step();
    drive_vec(25);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("bp_hold%0d_cnt", i), 64'(res_count), 64'd6);
      chk_c($sformatf("bp_hold%0d", i), 55, 58, 127, 134);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_r1_valid", 64'(out_valid), 64'd1);
    chk_c("bp_r1", 67, 70, 155, 162);
    chk("bp_r1_cnt", 64'(res_count), 64'd7);
    step();
    chk("bp_r2_valid", 64'(out_valid), 64'd1);
    chk_c("bp_r2", 79, 82, 183, 190);
    chk("bp_r2_cnt", 64'(res_count), 64'd8);
    step();
    chk("bp_drain_valid", 64'(out_valid), 64'd0);
    chk("bp_drain_cnt", 64'(res_count), 64'd9);

    // Asynchronous reset with two vectors in flight.
    drive_vec(17);
    step();
    drive_vec(21);
    step();
    in_valid = 1'b0;
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_cnt", 64'(res_count), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk_c("ar", 0, 0, 0, 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ar_post%0d_valid", i), 64'(out_valid), 64'd0);
      chk($sformatf("ar_post%0d_cnt", i), 64'(res_count), 64'd0);
    end

    // Counter wrap: 17 deliveries on a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      drive_vec(17);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_mid_cnt", 64'(res_count), 64'd15);
    step();
    chk("wrap_zero_cnt", 64'(res_count), 64'd0);
    step();
    step();
    chk("wrap_valid_off", 64'(out_valid), 64'd0);
    chk("wrap_cnt", 64'(res_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul2x2_pipe.md
Name: matmul2x2_pipe

Overview:
Downstream compute stage of the 2x2 matrix multiplier. Consumes the four row-major elements of matrix A (from operand memory 1) and of matrix B (from operand memory 2, the stage that produces M2Out1..M2Out4) and produces C = A x B. Two-stage pipeline: multiply, then add. Valid/ready handshake on input and output with full-pipeline stall under backpressure. Counts delivered results.

Parameters:
DW, 8, operand element width (unsigned)
CW, 16, width of delivered-result counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
A1  input  DW  a11
A2  input  DW  a12
A3  input  DW  a21
A4  input  DW  a22
B1  input  DW  b11 (driven by M2Out1)
B2  input  DW  b12 (driven by M2Out2)
B3  input  DW  b21 (driven by M2Out3)
B4  input  DW  b22 (driven by M2Out4)
in_valid  input  1  A/B operands valid this cycle
in_ready  output  1  stage accepts operands this cycle
C1  output  2*DW+1  c11 = a11*b11 + a12*b21
C2  output  2*DW+1  c12 = a11*b12 + a12*b22
C3  output  2*DW+1  c21 = a21*b11 + a22*b21
C4  output  2*DW+1  c22 = a21*b12 + a22*b22
out_valid  output  1  C1..C4 hold a valid result
out_ready  input  1  consumer accepts result
res_count  output  CW  number of results delivered since reset

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation): C1..C4=0, out_valid=0, res_count=0, stage-1 valid=0, stage-1 product registers=0. In-flight data discarded. in_ready=1 during and after reset.
- Arithmetic: all unsigned. Stage 1 registers eight 2*DW-bit products (a11*b11, a12*b21, a11*b12, a12*b22, a21*b11, a22*b21, a21*b12, a22*b22). Stage 2 registers four 2*DW+1-bit sums. No truncation, no overflow possible (max 2*(2^DW-1)^2 fits).
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational). While stall=1 all pipeline registers and valids hold.
- Input accept: in_valid & in_ready loads stage 1 and sets s1_valid=1; in_ready & ~in_valid loads s1_valid=0 (bubble). Operands presented while in_ready=0 are ignored; upstream must hold them.
- Advance: when ~stall, stage-2 registers load from stage-1 sums and out_valid <= s1_valid.
- Latency: accepted operands at edge N appear with out_valid=1 after edge N+1 (2 cycles, no stall). Throughput: one result per cycle when out_ready=1.
- Output stability: while out_valid=1 & out_ready=0, C1..C4 and out_valid constant.
- Handshake complete: out_valid & out_ready at an edge -> res_count increments by 1, wraps 2^CW-1 -> 0.
- out_ready asserted with out_valid=0: no effect on counter.
- Simultaneous accept at input and delivery at output in same cycle: both take effect.

Test Plan:
- Basic: A=[1,2,3,4], B=[17,18,19,20], in_valid=1 one cycle, out_ready=1 -> two cycles later out_valid=1 one cycle, C=[55,58,127,134], res_count=1.
- Max values: all A,B=255 -> C1..C4=130050 each, no overflow.
- Streaming: 4 back-to-back vectors (B=[17..20],[21..24],[25..28],[29..32], A=[1,2,3,4]) -> four consecutive out_valid cycles, first C=[55,58,127,134], second C=[67,70,155,162], res_count=4.
- Backpressure: out_ready=0 with pipeline full -> in_ready=0, C held constant for 5 cycles, no count change; release -> remaining results emerge in order, none lost or duplicated.
- Reset mid-flight: rst=0 asserted asynchronously between edges with two vectors in pipeline -> outputs, out_valid, res_count immediately 0; after release, no stale results appear.
- Counter wrap (CW=4 in bench): 17 delivered results -> res_count reads 1.
